// File: rtl/pr_en_mux.sv
// Registered 4-input selector with mux and fixed-priority modes.
// Data is steered through AND-OR masking, so X on an unselected input never reaches out.
module pr_en_mux_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             gnt,
  output logic [WIDTH-1:0] masked
);
  assign masked = data & {WIDTH{gnt}};
endmodule

module pr_en_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             mode,
  input  logic [3:0]       req,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       idx,
  output logic             valid
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       idx;
    logic             valid;
  } sel_t;

  logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
  logic [NUM_LANES-1:0][WIDTH-1:0] masked;
  logic [NUM_LANES-1:0]            gnt;
  sel_t                            nxt;
  sel_t                            cur;

  assign lanes = {d, c, b, a};

  // One-hot grant: decoded sel, or the lowest set request bit (a wins).
  always_comb begin
    gnt = '0;
    if (!mode) gnt[sel] = 1'b1;
    else       gnt = req & (~req + 4'd1);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pr_en_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .data   (lanes[g]),
      .gnt    (gnt[g]),
      .masked (masked[g])
    );
  end

  always_comb begin
    nxt       = '0;
    nxt.valid = |gnt;
    for (int i = 0; i < NUM_LANES; i++) begin
      nxt.data = nxt.data | masked[i];
      if (gnt[i]) nxt.idx = nxt.idx | 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cur <= '0;
    else if (en) cur <= nxt;
  end

  assign out   = cur.data;
  assign idx   = cur.idx;
  assign valid = cur.valid;
endmodule

// File: tb/tb_pr_en_mux.sv
// Directed plus randomized checks of pr_en_mux against a behavioural model.
module tb_pr_en_mux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0, c = '0, d = '0;
  logic [1:0] sel = '0;
  logic       mode = 1'b0;
  logic [3:0] req = '0;
  logic       en = 1'b0;
  logic [7:0] out;
  logic [1:0] idx;
  logic       valid;

  int tests = 0;
  int fails = 0;
  logic [7:0] e_out = '0;
  logic [1:0] e_idx = '0;
  logic       e_vld = 1'b0;

  pr_en_mux #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .sel(sel), .mode(mode), .req(req), .en(en),
    .out(out), .idx(idx), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".idx"}, {6'd0, idx}, {6'd0, e_idx});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, e_vld});
  endtask

  // Reference: what the selection rules pick from the current inputs.
  task automatic model_next(output logic [7:0] o, output logic [1:0] ix, output logic v);
    logic [7:0] ins [4];
    ins = '{a, b, c, d};
    o = '0; ix = '0; v = 1'b0;
    if (!mode) begin
      o = ins[sel]; ix = sel; v = 1'b1;
    end else begin
      for (int k = 3; k >= 0; k--)
        if (req[k]) begin o = ins[k]; ix = 2'(k); v = 1'b1; end
    end
  endtask

  // Capture the model at the edge, then sample the DUT 1 time unit later.
  task automatic cycle(input string tag);
    logic [7:0] o; logic [1:0] ix; logic v;
    model_next(o, ix, v);
    @(posedge clk);
    if (en && !rst) begin e_out = o; e_idx = ix; e_vld = v; end
    #1;
    chk_all(tag);
  endtask

  initial begin
    // Power-on reset held across edges
    repeat (2) @(posedge clk);
    #1;
    chk_all("por");
    rst = 1'b0;

    // Reset mid-run with out=5A
    en = 1'b1; mode = 1'b0; sel = 2'd0; a = 8'h5A;
    cycle("pre_rst");
    #2 rst = 1'b1;
    #1;
    e_out = '0; e_idx = '0; e_vld = 1'b0;
    chk_all("rst_async");
    cycle("rst_held");
    rst = 1'b0;

    // Mux sweep
    a = 8'h24; b = 8'h81; c = 8'h09; d = 8'h63;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cycle("mux_sweep");
    end
    chk("mux_sweep_last", out, 8'h63);

    // Priority cases
    mode = 1'b1; a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    req = 4'b1100; cycle("prio_1100"); chk("prio_1100_lit", out, 8'h33);
    req = 4'b1111; cycle("prio_1111"); chk("prio_1111_lit", out, 8'h11);
    req = 4'b1000; cycle("prio_1000"); chk("prio_1000_lit", out, 8'h44);

    // No request, then b alone
    req = 4'b0000; cycle("no_req");
    req = 4'b0010; cycle("req_b"); chk("req_b_lit", out, 8'h22);

    // Hold with en=0
    mode = 1'b0; a = 8'h24; b = 8'h81; sel = 2'd1;
    cycle("hold_cap");
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s ^ 2); a = 8'(s + 8'hC0); b = 8'(s + 8'hD0);
      cycle("hold");
      chk("hold_lit", out, 8'h81);
    end
    en = 1'b1;
    cycle("hold_release");

    // Latency: change sel between edges, out must not move until next edge
    sel = 2'd3; d = 8'h63;
    cycle("lat_a");
    sel = 2'd0; a = 8'h7E;
    #2;
    chk("lat_comb", out, 8'h63);
    cycle("lat_b");

    // X on unselected inputs must not leak
    a = 8'hA5; b = 'x; c = 'x; d = 'x; sel = 2'd0; mode = 1'b0;
    cycle("x_mux");
    mode = 1'b1; req = 4'b0001;
    cycle("x_prio");
    b = 8'h00; c = 8'h00; d = 8'h00;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      sel  = 2'($urandom);
      mode = 1'($urandom);
      req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      en   = ($urandom_range(0, 4) != 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
